// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types for the instruction fetch stage: instruction bus request and
// response records, the fetch FSM state encoding, the output holding-register
// record, the default reset PC and the PC increment helper.
// Optional feature macro used by importers: FETCH_MISALIGN_CHECK_EN.
// -----------------------------------------------------------------------------
package fetch_pkg;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
   } ibus_req_t;

   typedef struct packed {
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] pc;
      logic [31:0] raw;
      logic        misalign;
   } fetch_data_t;

   localparam logic [63:0] PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;

   localparam fetch_data_t HOLD_RESET = '{valid: 1'b0, pc: 64'd0, raw: 32'd0, misalign: 1'b0};

   // Sequential PC step; wraps modulo 2^64.
   function automatic logic [63:0] next_pc(input logic [63:0] pc);
      return pc + 64'd4;
   endfunction

endpackage

// File: rtl/fetch_hold.sv
// -----------------------------------------------------------------------------
// fetch_hold
// Single-entry output register between fetch and decode.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   capture      - load cap_data (valid forced to 1)
//   cap_data     - record to load
//   dequeue      - decode consumed the entry this cycle
//   flush        - drop the entry (redirect); wins over capture
//   hold         - registered contents
// A capture coinciding with a dequeue overwrites the entry and stays valid.
// -----------------------------------------------------------------------------
module fetch_hold
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        capture,
   input  fetch_data_t cap_data,
   input  logic        dequeue,
   input  logic        flush,
   output fetch_data_t hold
);

   fetch_data_t hold_q;
   fetch_data_t hold_d;

   // Next entry: flush > capture > dequeue > keep.
   always_comb begin
      hold_d = hold_q;
      if (flush) begin
         hold_d.valid = 1'b0;
      end else if (capture) begin
         hold_d       = cap_data;
         hold_d.valid = 1'b1;
      end else if (dequeue) begin
         hold_d.valid = 1'b0;
      end else begin
         hold_d = hold_q;
      end
   end

   // Entry register.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q <= HOLD_RESET;
      end else begin
         hold_q <= hold_d;
      end
   end

   assign hold = hold_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch: owns the PC, issues reads on the instruction bus, and
// hands {pc, raw} to decode through a valid/ready holding register. Handles
// bus wait states, decode back-pressure and redirects; responses made stale
// by a redirect are discarded (DROP state).
// Ports:
//   clk, reset                - clock, synchronous active-high reset
//   ireq / iresp              - instruction bus request / response
//   redirect_valid/_pc        - taken branch/jump target from execute
//   out_valid/out_ready       - handshake to decode
//   out_pc, out_raw           - held instruction
//   out_misalign              - only with FETCH_MISALIGN_CHECK_EN
// Macro FETCH_MISALIGN_CHECK_EN: a misaligned PC produces a flagged empty
// instruction instead of a bus request, then fetch halts until a redirect.
// -----------------------------------------------------------------------------
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT
)(
   input  logic        clk,
   input  logic        reset,
   output ibus_req_t   ireq,
   input  ibus_resp_t  iresp,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_pc,
   output logic [31:0] out_raw
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic        out_misalign
`endif
);

   fetch_state_t state_q, state_d;
   logic [63:0]  pc_q, pc_d;
   logic [63:0]  req_addr_q, req_addr_d;
   logic         req_valid_s;
   logic [63:0]  req_addr_s;
   logic         capture_s;
   fetch_data_t  cap_s;
   logic         can_issue_s;
   logic         dequeue_s;
   fetch_data_t  hold_s;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic         halt_q, halt_d;
`else
   logic         unused_misalign;
   assign unused_misalign = hold_s.misalign;
`endif

   assign can_issue_s = !hold_s.valid || out_ready;
   assign dequeue_s   = hold_s.valid && out_ready;

   // Fetch FSM: next state, PC, bus request and capture control.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_addr_d  = req_addr_q;
      req_valid_s = 1'b0;
      req_addr_s  = pc_q;
      capture_s   = 1'b0;
      cap_s       = '{valid: 1'b1, pc: pc_q, raw: iresp.data, misalign: 1'b0};
`ifdef FETCH_MISALIGN_CHECK_EN
      halt_d      = halt_q;
`endif
      case (state_q)
         IDLE: begin
            if (redirect_valid) begin
               pc_d = redirect_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
               halt_d = 1'b0;
            end else if (halt_q) begin
               pc_d = pc_q;
            end else if ((pc_q[1:0] != 2'b00) && can_issue_s) begin
               // Deliver a flagged empty instruction instead of touching the bus.
               capture_s      = 1'b1;
               cap_s.raw      = 32'h0000_0000;
               cap_s.misalign = 1'b1;
               halt_d         = 1'b1;
`endif
            end else if (can_issue_s) begin
               req_valid_s = 1'b1;
               if (iresp.data_ok) begin
                  capture_s = 1'b1;
                  pc_d      = next_pc(pc_q);
               end else begin
                  req_addr_d = pc_q;
                  state_d    = REQ;
               end
            end else begin
               pc_d = pc_q;
            end
         end
         REQ: begin
            req_valid_s = 1'b1;
            req_addr_s  = req_addr_q;
            if (redirect_valid) begin
               pc_d    = redirect_pc;
               state_d = iresp.data_ok ? IDLE : DROP;
            end else if (iresp.data_ok) begin
               capture_s = 1'b1;
               cap_s.pc  = req_addr_q;
               pc_d      = next_pc(req_addr_q);
               state_d   = IDLE;
            end else begin
               state_d = REQ;
            end
         end
         DROP: begin
            // Keep the abandoned request stable until its response arrives.
            // If that response coincides with another redirect, nothing is
            // left outstanding, so return to IDLE rather than drop again.
            req_valid_s = 1'b1;
            req_addr_s  = req_addr_q;
            if (redirect_valid) begin
               pc_d = redirect_pc;
            end else begin
               pc_d = pc_q;
            end
            if (iresp.data_ok) begin
               state_d = IDLE;
            end else begin
               state_d = DROP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Bus request; forced to the reset view while reset is asserted.
   always_comb begin
      if (reset) begin
         ireq.valid = 1'b0;
         ireq.addr  = PC_RESET;
      end else begin
         ireq.valid = req_valid_s;
         ireq.addr  = req_addr_s;
      end
   end

   // FSM, PC and request-address registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         pc_q       <= PC_RESET;
         req_addr_q <= PC_RESET;
`ifdef FETCH_MISALIGN_CHECK_EN
         halt_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
         halt_q     <= halt_d;
`endif
      end
   end

   fetch_hold u_hold (
      .clk      (clk),
      .reset    (reset),
      .capture  (capture_s),
      .cap_data (cap_s),
      .dequeue  (dequeue_s),
      .flush    (redirect_valid),
      .hold     (hold_s)
   );

   assign out_valid = hold_s.valid;
   assign out_pc    = hold_s.pc;
   assign out_raw   = hold_s.raw;
`ifdef FETCH_MISALIGN_CHECK_EN
   assign out_misalign = hold_s.misalign;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed, table-driven bench for fetch_unit. Each table row is one clock
// cycle: inputs applied after a rising edge, outputs sampled 1 time unit
// later, then the next edge. Misalign/wrap corners follow as hand sequences.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam logic [63:0] P = 64'h0000_0000_8000_0000;

   logic        clk;
   logic        reset;
   ibus_req_t   ireq;
   ibus_resp_t  iresp;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [31:0] out_raw;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        out_misalign;
`endif

   int total = 0;
   int bad   = 0;

   fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .ireq           (ireq),
      .iresp          (iresp),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_raw        (out_raw)
`ifdef FETCH_MISALIGN_CHECK_EN
      ,
      .out_misalign   (out_misalign)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        dok;
      logic [31:0] data;
      logic        rv;
      logic [63:0] rpc;
      logic        ordy;
      logic        e_iv;
      logic [63:0] e_ia;
      logic        e_ov;
      logic        chk_out;
      logic [63:0] e_opc;
      logic [31:0] e_oraw;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, input logic dok, input logic [31:0] data,
                               input logic rv, input logic [63:0] rpc, input logic ordy,
                               input logic e_iv, input logic [63:0] e_ia, input logic e_ov,
                               input logic chk_out, input logic [63:0] e_opc,
                               input logic [31:0] e_oraw);
      vec_t v;
      v.rst = rst; v.dok = dok; v.data = data; v.rv = rv; v.rpc = rpc; v.ordy = ordy;
      v.e_iv = e_iv; v.e_ia = e_ia; v.e_ov = e_ov; v.chk_out = chk_out;
      v.e_opc = e_opc; v.e_oraw = e_oraw;
      return v;
   endfunction

   task automatic apply(input logic r, input logic d, input logic [31:0] dt,
                        input logic rv, input logic [63:0] rp, input logic o);
      reset          = r;
      iresp.data_ok  = d;
      iresp.data     = dt;
      redirect_valid = rv;
      redirect_pc    = rp;
      out_ready      = o;
      #1;
   endtask

   task automatic chk(input string nm, input int step, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s step %0d: got %h want %h", nm, step, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // rst dok data rv rpc ordy | iv ia ov chk opc raw
      vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1, 1'b0, P, 1'b0, 1'b1, 64'h0, 32'h0));
      // zero-wait memory, back-to-back
      vecs.push_back(mk(1'b0, 1'b1, 32'hC0DE_0000, 1'b0, 64'h0, 1'b1, 1'b1, P,         1'b0, 1'b0, 64'h0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b1, 32'hC0DE_0004, 1'b0, 64'h0, 1'b1, 1'b1, P + 64'h4, 1'b1, 1'b1, P, 32'hC0DE_0000));
      vecs.push_back(mk(1'b0, 1'b1, 32'hC0DE_0008, 1'b0, 64'h0, 1'b1, 1'b1, P + 64'h8, 1'b1, 1'b1, P + 64'h4, 32'hC0DE_0004));
      // decode stall for 3 cycles, then release
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0, 1'b0, P + 64'hC, 1'b1, 1'b1, P + 64'h8, 32'hC0DE_0008));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1, 1'b1, P + 64'hC, 1'b1, 1'b1, P + 64'h8, 32'hC0DE_0008));
      // wait states: data_ok 3 cycles after issue
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1, 1'b1, P + 64'hC, 1'b0, 1'b0, 64'h0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1, 1'b1, P + 64'hC, 1'b0, 1'b0, 64'h0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b1, 32'hC0DE_000C, 1'b0, 64'h0, 1'b1, 1'b1, P + 64'hC, 1'b0, 1'b0, 64'h0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1, 1'b1, P + 64'h10, 1'b1, 1'b1, P + 64'hC, 32'hC0DE_000C));
      // redirect while REQ waits: old response dropped
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, P + 64'h100, 1'b1, 1'b1, P + 64'h10, 1'b0, 1'b0, 64'h0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1, 1'b1, P + 64'h10, 1'b0, 1'b0, 64'h0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 64'h0, 1'b1, 1'b1, P + 64'h10, 1'b0, 1'b0, 64'h0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1, 1'b1, P + 64'h100, 1'b0, 1'b0, 64'h0, 32'h0));
      // redirect coincident with data_ok in REQ
      vecs.push_back(mk(1'b0, 1'b1, 32'hC0DE_0100, 1'b1, P + 64'h200, 1'b1, 1'b1, P + 64'h100, 1'b0, 1'b0, 64'h0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b1, 32'hC0DE_0200, 1'b0, 64'h0, 1'b1, 1'b1, P + 64'h200, 1'b0, 1'b0, 64'h0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1, 1'b1, P + 64'h204, 1'b1, 1'b1, P + 64'h200, 32'hC0DE_0200));
      vecs.push_back(mk(1'b0, 1'b1, 32'hC0DE_0204, 1'b0, 64'h0, 1'b1, 1'b1, P + 64'h204, 1'b0, 1'b0, 64'h0, 32'h0));
      // redirect in IDLE with hold full and stalled: hold flushed
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, P + 64'h300, 1'b0, 1'b0, P + 64'h208, 1'b1, 1'b1, P + 64'h204, 32'hC0DE_0204));
      vecs.push_back(mk(1'b0, 1'b1, 32'hC0DE_0300, 1'b0, 64'h0, 1'b1, 1'b1, P + 64'h300, 1'b0, 1'b0, 64'h0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1, 1'b1, P + 64'h304, 1'b1, 1'b1, P + 64'h300, 32'hC0DE_0300));
      // reset mid-request, then restart from PC_RESET
      vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1, 1'b0, P, 1'b0, 1'b0, 64'h0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1, 1'b1, P, 1'b0, 1'b1, 64'h0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b1, 32'h1357_9BDF, 1'b0, 64'h0, 1'b1, 1'b1, P, 1'b0, 1'b0, 64'h0, 32'h0));
      // redirect to a misaligned target while IDLE with hold draining
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, P + 64'h102, 1'b1, 1'b0, P + 64'h4, 1'b1, 1'b1, P, 32'h1357_9BDF));

      apply(1'b1, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
      tick();
      tick();

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].rst, vecs[i].dok, vecs[i].data, vecs[i].rv, vecs[i].rpc, vecs[i].ordy);
         chk("ireq_valid", i, {63'd0, ireq.valid}, {63'd0, vecs[i].e_iv});
         if (vecs[i].e_iv || vecs[i].rst)
            chk("ireq_addr", i, ireq.addr, vecs[i].e_ia);
         chk("out_valid", i, {63'd0, out_valid}, {63'd0, vecs[i].e_ov});
         if (vecs[i].chk_out) begin
            chk("out_pc", i, out_pc, vecs[i].e_opc);
            chk("out_raw", i, {32'd0, out_raw}, {32'd0, vecs[i].e_oraw});
`ifdef FETCH_MISALIGN_CHECK_EN
            chk("out_misalign", i, {63'd0, out_misalign}, 64'd0);
`endif
         end
         tick();
      end

`ifdef FETCH_MISALIGN_CHECK_EN
      // misaligned PC: flagged empty instruction, no request, then halt
      apply(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
      chk("mis_no_req", 100, {63'd0, ireq.valid}, 64'd0);
      chk("mis_ov_before", 100, {63'd0, out_valid}, 64'd0);
      tick();
      apply(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
      chk("mis_ov", 101, {63'd0, out_valid}, 64'd1);
      chk("mis_flag", 101, {63'd0, out_misalign}, 64'd1);
      chk("mis_raw", 101, {32'd0, out_raw}, 64'd0);
      chk("mis_pc", 101, out_pc, P + 64'h102);
      chk("mis_no_req2", 101, {63'd0, ireq.valid}, 64'd0);
      tick();
      apply(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
      chk("halt_no_req", 102, {63'd0, ireq.valid}, 64'd0);
      chk("halt_ov", 102, {63'd0, out_valid}, 64'd0);
      tick();
      apply(1'b0, 1'b0, 32'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
      chk("redir_no_req", 103, {63'd0, ireq.valid}, 64'd0);
      tick();
`else
      // without the check the misaligned PC goes straight onto the bus
      apply(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 64'h0, 1'b1);
      chk("mis_req", 100, {63'd0, ireq.valid}, 64'd1);
      chk("mis_addr", 100, ireq.addr, P + 64'h102);
      tick();
      apply(1'b0, 1'b0, 32'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
      chk("mis_ov", 101, {63'd0, out_valid}, 64'd1);
      chk("mis_pc", 101, out_pc, P + 64'h102);
      chk("mis_raw", 101, {32'd0, out_raw}, {32'd0, 32'hCAFE_F00D});
      chk("redir_no_req", 101, {63'd0, ireq.valid}, 64'd0);
      tick();
`endif

      // PC wrap at the top of the address space
      apply(1'b0, 1'b1, 32'h1234_5678, 1'b0, 64'h0, 1'b1);
      chk("wrap_req", 200, {63'd0, ireq.valid}, 64'd1);
      chk("wrap_addr0", 200, ireq.addr, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();
      apply(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
      chk("wrap_addr1", 201, ireq.addr, 64'h0);
      chk("wrap_ov", 201, {63'd0, out_valid}, 64'd1);
      chk("wrap_pc", 201, out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_raw", 201, {32'd0, out_raw}, {32'd0, 32'h1234_5678});
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
